// File: rtl/tchk_if.sv
// Packet FIFO read port between the FIFO and the checker.
// The FIFO side drives head data and empty; the checker drives the pop strobe.
interface tchk_if;
  logic [63:0] packet_fifo_rd_data;
  logic        packet_fifo_empty;
  logic        packet_fifo_re;

  modport master (
    output packet_fifo_rd_data,
    output packet_fifo_empty,
    input  packet_fifo_re
  );

  modport slave (
    input  packet_fifo_rd_data,
    input  packet_fifo_empty,
    output packet_fifo_re
  );
endinterface

// File: rtl/tchk.sv
// Test packet checker: pops words from a first-word-fall-through FIFO, hunts
// for start-of-packet, checks header sequence numbers and incrementing-lane
// payload, and keeps saturating good/bad/error counts plus a sticky error.
//
// state | meaning
// HUNT  | discarding words until SOP; new packets only start while enable=1
// HDR   | next popped word is the header (salt, reserved zero, sequence)
// DATA  | comparing payload words against the expected lane pattern
module tchk #(
  parameter int PKT_WORDS = 512
) (
  input  logic        clk,
  input  logic        reset_l,
  input  logic        enable,
  tchk_if.slave       fifo,
  output logic [31:0] pkt_good_count,
  output logic [31:0] pkt_bad_count,
  output logic [31:0] word_err_count,
  output logic [15:0] seq_err_count,
  output logic        error
);

  localparam int          CW       = $clog2(PKT_WORDS);
  localparam logic [CW-1:0] CNT_LOAD = CW'(PKT_WORDS - 3);
  localparam logic [63:0] SOP      = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef enum logic [1:0] {HUNT, HDR, DATA} state_t;

  state_t        state, state_nxt;
  logic [15:0]   exp_lane;
  logic [31:0]   exp_seq;
  logic          seq_locked;
  logic          bad;
  logic [CW-1:0] word_cnt;

  logic          pop;
  logic          is_sop;
  logic          data_mis;
  logic [63:0]   word;
  logic [63:0]   exp_word;
  logic          hdr_load, data_adv, mark_bad, clear_bad;
  logic          inc_good, inc_bad, inc_word, inc_seq;

  function automatic logic [31:0] sat32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [15:0] sat16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign word     = fifo.packet_fifo_rd_data;
  assign is_sop   = (word == SOP);
  assign exp_word = {exp_lane + 16'd3, exp_lane + 16'd2, exp_lane + 16'd1, exp_lane};
  assign data_mis = (word != exp_word);
  assign pop      = !fifo.packet_fifo_empty && (state != HUNT || enable);
  assign fifo.packet_fifo_re = pop;

  // State register; reset mid-packet simply drops the packet uncounted.
  always_ff @(posedge clk) begin
    if (!reset_l) state <= HUNT;
    else          state <= state_nxt;
  end

  // Next-state decode and per-word check results for the popped word.
  always_comb begin
    state_nxt = state;
    hdr_load  = 1'b0;
    data_adv  = 1'b0;
    mark_bad  = 1'b0;
    clear_bad = 1'b0;
    inc_good  = 1'b0;
    inc_bad   = 1'b0;
    inc_word  = 1'b0;
    inc_seq   = 1'b0;
    case (state)
      HUNT: begin
        if (pop && is_sop) begin
          state_nxt = HDR;
          clear_bad = 1'b1;
        end
      end
      HDR: begin
        if (pop) begin
          if (is_sop) begin
            inc_word = 1'b1;
            mark_bad = 1'b1;
          end else begin
            hdr_load  = 1'b1;
            state_nxt = DATA;
            if (word[47:32] != 16'h0000) begin
              inc_word = 1'b1;
              mark_bad = 1'b1;
            end
            if (seq_locked && word[31:0] != exp_seq) begin
              inc_seq  = 1'b1;
              mark_bad = 1'b1;
            end
          end
        end
      end
      DATA: begin
        if (pop) begin
          if (is_sop) begin
            // Truncated packet: count it bad and treat this SOP as the next one.
            inc_bad   = 1'b1;
            inc_word  = 1'b1;
            clear_bad = 1'b1;
            state_nxt = HDR;
          end else begin
            data_adv = 1'b1;
            if (data_mis) begin
              inc_word = 1'b1;
              mark_bad = 1'b1;
            end
            if (word_cnt == '0) begin
              state_nxt = HUNT;
              if (bad || data_mis) inc_bad  = 1'b1;
              else                 inc_good = 1'b1;
            end
          end
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  // Expected-value tracking, packet flags and saturating counters.
  always_ff @(posedge clk) begin
    if (!reset_l) begin
      exp_lane       <= '0;
      exp_seq        <= '0;
      seq_locked     <= 1'b0;
      bad            <= 1'b0;
      word_cnt       <= '0;
      pkt_good_count <= '0;
      pkt_bad_count  <= '0;
      word_err_count <= '0;
      seq_err_count  <= '0;
      error          <= 1'b0;
    end else begin
      if (clear_bad)     bad <= 1'b0;
      else if (mark_bad) bad <= 1'b1;
      if (hdr_load) begin
        exp_lane   <= word[63:48] + 16'd1;
        word_cnt   <= CNT_LOAD;
        seq_locked <= 1'b1;
        exp_seq    <= word[31:0] + 32'd1;
      end
      // Lanes advance even on a mismatch so one bad word costs one error.
      if (data_adv) begin
        exp_lane <= exp_lane + 16'd4;
        word_cnt <= word_cnt - 1'b1;
      end
      if (inc_good) pkt_good_count <= sat32(pkt_good_count);
      if (inc_bad)  pkt_bad_count  <= sat32(pkt_bad_count);
      if (inc_word) word_err_count <= sat32(word_err_count);
      if (inc_seq)  seq_err_count  <= sat16(seq_err_count);
      if (inc_bad || inc_word || inc_seq) error <= 1'b1;
    end
  end

endmodule
